pkt_switch4: RTL and testbench
==============================

Name: pkt_switch4

Overview:
- 4-input / 4-output wormhole packet switch for the on-chip packet network.
- Each input port carries a stream of 10-bit flits into a per-input FIFO. Packets are routed by the head flit's destination field to one of four outputs.
- Each output has a round-robin arbiter and stays locked to one input from head flit to tail flit.

Parameters:
- PKTW, 9, MSB index of a flit; flit width is PKTW+1 = 10. Lives in the shared package.
- FIFO_DEPTH, 8, entries per input FIFO; must be a power of two and at least 4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset (ASSERT=1, NEGATE=0).
- i0..i3  in  PKTW+1  input flit per port, sampled every rising edge.
- o0..o3  out  PKTW+1  registered output flit per port.

Behaviour:
- Flit format: [9:8] type, [7:0] payload.
  - Types: 00 = idle, 10 = head, 01 = body, 11 = tail.
  - Head flit: payload[1:0] is the destination port. payload[7:2] is free data, conventionally [7:4] = source id.
- Packet grammar: head, then zero or more body flits, then tail; minimum length 2.
  - No backpressure exists toward senders.
  - A flit arriving at a full FIFO is dropped.
  - A stray body/tail flit reaching a FIFO head with no owning lock is popped and discarded.
- Input stage:
  - Every non-idle flit (type != 00) is pushed into that input's FIFO on the rising edge.
  - Idle flits are never stored.
- Arbitration (one arbiter per output, combinational grant):
  - Requesters are inputs whose FIFO head is a head flit with destination equal to this output, and which are not currently locked to another output.
  - Round-robin starts from the pointer; after reset the pointer is 0, so input 0 has highest priority.
  - After a packet from input k completes, the pointer moves to k+1 mod 4.
- Forwarding:
  - On grant, the head flit is popped, registered onto the output, and the lock (output -> input) is set, all at the same edge.
  - While locked, each cycle the owning FIFO is non-empty, its head flit is popped and registered to the output.
  - If the owning FIFO is empty mid-packet, the output shows 0 (idle) and the lock holds.
  - When a tail flit is forwarded, the lock clears at that edge. A new grant may occur on the very next edge, so packets go back-to-back with no bubble.
- Latency: a flit sampled at edge T appears on the output after edge T+1 when uncontended. Minimum latency is 2 clock edges from drive to visible output.
- Outputs are 0 whenever no flit is forwarded in that cycle.
- Each input serves at most one output at a time. There is head-of-line blocking per input FIFO.
- Loopback (input k to output k) is a legal route.
- Simultaneous events:
  - Push and pop on the same FIFO in the same cycle are allowed, including when the FIFO is full.
  - All four outputs may forward in parallel from distinct inputs.
- Reset (asynchronous, any time, including mid-packet):
  - All FIFOs are emptied, all locks cleared, arbiter pointers set to 0, o0..o3 = 0.
  - Partial packets are lost.

Decomposition:
- Package sw_pkg holds:
  - PKTW and the flit type constants IDLE, HEAD, BODY, TAIL.
  - ASSERT/NEGATE.
  - A flit typedef and the destination-field helper.
- Sub-module sw_fifo (synchronous FIFO: push, pop, full, empty, head data, async reset) is instantiated 4 times.
- Arbitration and the crossbar stay in the top module.

Test Plan:
- Reset then idle: assert rst for 1 cycle -> o0..o3 = 0 during and after reset.
- Single route: i0 drives 10_0000_0000, 01_0000_0000, 01_0000_0001, 11_0000_0010 on consecutive cycles.
  - Required: o0 shows the same 4 flits 2 edges later, consecutively.
  - o1..o3 stay 0.
- Full route matrix: for every src s and dst d, drive 2-flit packet 10_{s}_{00dd}, 11_{s}_1111 on input s.
  - Required: exactly those 2 flits on output d, latency 2.
  - All other outputs 0.
- 4-way conflict, first after reset: all inputs drive a 4-flit packet to port 1 in the same cycle.
  - Required: o1 carries 16 consecutive flits in order i0, i1, i2, i3, each packet contiguous and uninterrupted.
  - No flits lost.
- Round-robin fairness: repeat the 2-flit conflict to ports 0, 1, 2, 3.
  - Required: each output serializes all 4 packets unbroken.
  - Start order follows each output's pointer.
- Mid-packet stall and reset:
  - Gap (idle) between body flits -> output shows 0 for the gap, lock holds, and no other input interleaves.
  - rst asserted mid-packet -> outputs 0 immediately and a subsequent packet routes correctly.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the 4-port wormhole packet switch.
// Holds the flit layout, flit type codes, reset levels and the route helper.
package sw_pkg;

  localparam int unsigned PKTW   = 9;          // MSB index of a flit
  localparam int unsigned FLITW  = PKTW + 1;   // flit width
  localparam int unsigned NPORTS = 4;
  localparam int unsigned PORTW  = 2;

  // Flit type codes carried in flit[9:8]
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] HEAD = 2'b10;
  localparam logic [1:0] BODY = 2'b01;
  localparam logic [1:0] TAIL = 2'b11;

  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  typedef struct packed {
    logic [1:0]      kind;
    logic [PKTW-2:0] payload;
  } flit_t;

  // Destination port of a head flit
  function automatic logic [PORTW-1:0] flit_dest(input flit_t f);
    return f.payload[PORTW-1:0];
  endfunction

endpackage

// File: rtl/pkt_switch4_if.sv
// Flit bus of the 4-port switch.
//   i0..i3 : input flits, one per port, sampled every rising edge
//   o0..o3 : registered output flits, one per port
// master = traffic source/sink side, slave = switch side.
interface pkt_switch4_if;

  sw_pkg::flit_t i0, i1, i2, i3;
  sw_pkg::flit_t o0, o1, o2, o3;

  modport master (output i0, i1, i2, i3, input  o0, o1, o2, o3);
  modport slave  (input  i0, i1, i2, i3, output o0, o1, o2, o3);

endinterface

// File: rtl/sw_fifo.sv
// Per-input synchronous flit FIFO with asynchronous active-high reset.
//   clk, rst : clock, async reset (empties the FIFO)
//   push     : write din this edge (caller only pushes when not full or popping)
//   pop      : drop the head entry this edge (caller only pops when not empty)
//   din      : flit to write
//   head_c   : current head entry (valid while !empty_c)
//   full_c   : FIFO holds DEPTH entries
//   empty_c  : FIFO holds no entries
// DEPTH must be a power of two so the pointers wrap naturally.
module sw_fifo
  import sw_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t din,
  output flit_t head_c,
  output logic  full_c,
  output logic  empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  flit_t         mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];

  // Storage array needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst == ASSERT) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pkt_switch4.sv
// 4-input / 4-output wormhole packet switch.
//   clk, rst : clock, async active-high reset (empties FIFOs, clears locks)
//   bus      : pkt_switch4_if.slave, flit inputs i0..i3, registered outputs o0..o3
// Each input feeds a FIFO; each output runs a round-robin arbiter over FIFO
// heads addressed to it and stays locked to the winning input until the tail.
module pkt_switch4
  import sw_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  pkt_switch4_if.slave  bus
);

  flit_t             in_flit [NPORTS];
  flit_t             head    [NPORTS];
  logic [NPORTS-1:0] push;
  logic [NPORTS-1:0] pop;
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] empty;
  logic [NPORTS-1:0] busy;

  logic [NPORTS-1:0] locked;
  logic [PORTW-1:0]  owner     [NPORTS];
  logic [PORTW-1:0]  ptr       [NPORTS];
  flit_t             out_q     [NPORTS];

  logic [NPORTS-1:0] grant;
  logic [PORTW-1:0]  grant_idx [NPORTS];
  logic [NPORTS-1:0] rel;
  flit_t             fwd       [NPORTS];

  // Round-robin pick: first requester at or after ptr; returns {valid, index}
  function automatic logic [PORTW:0] rr_pick(input logic [NPORTS-1:0] req,
                                             input logic [PORTW-1:0]  start);
    logic [PORTW:0]   res;
    logic [PORTW-1:0] k;
    res = '0;
    // Walk from the farthest offset back so the nearest requester wins
    for (int off = int'(NPORTS) - 1; off >= 0; off--) begin
      k = start + PORTW'(off);
      if (req[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  always_comb begin : in_map
    in_flit[0] = bus.i0;
    in_flit[1] = bus.i1;
    in_flit[2] = bus.i2;
    in_flit[3] = bus.i3;
  end

  for (genvar k = 0; k < NPORTS; k++) begin : g_fifo
    sw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[k]),
      .pop     (pop[k]),
      .din     (in_flit[k]),
      .head_c  (head[k]),
      .full_c  (full[k]),
      .empty_c (empty[k])
    );
  end

  // Non-idle flits are stored; a full FIFO still accepts if it pops this edge
  always_comb begin : push_ctl
    for (int k = 0; k < NPORTS; k++) begin
      push[k] = (in_flit[k].kind != IDLE) && (!full[k] || pop[k]);
    end
  end

  // Inputs currently owned by some output
  always_comb begin : busy_map
    busy = '0;
    for (int d = 0; d < NPORTS; d++) begin
      if (locked[d]) busy[owner[d]] = 1'b1;
    end
  end

  // Arbitration, crossbar selection and FIFO pops
  always_comb begin : route
    logic [NPORTS-1:0] req;
    logic [PORTW:0]    pick;
    req   = '0;
    pick  = '0;
    pop   = '0;
    grant = '0;
    rel   = '0;
    for (int d = 0; d < NPORTS; d++) begin
      fwd[d]       = '0;
      grant_idx[d] = '0;
    end

    for (int d = 0; d < NPORTS; d++) begin
      if (locked[d]) begin
        // Mid-packet: forward whatever the owner has; empty means a stall
        if (!empty[owner[d]]) begin
          pop[owner[d]] = 1'b1;
          fwd[d]        = head[owner[d]];
          rel[d]        = (head[owner[d]].kind == TAIL);
        end
      end else begin
        for (int k = 0; k < NPORTS; k++) begin
          req[k] = !empty[k] && !busy[k] && (head[k].kind == HEAD) &&
                   (flit_dest(head[k]) == PORTW'(d));
        end
        pick = rr_pick(req, ptr[d]);
        if (pick[PORTW]) begin
          grant[d]                 = 1'b1;
          grant_idx[d]             = pick[PORTW-1:0];
          pop[pick[PORTW-1:0]]     = 1'b1;
          fwd[d]                   = head[pick[PORTW-1:0]];
        end
      end
    end

    // Body/tail at the head of an unowned FIFO has lost its packet: discard
    for (int k = 0; k < NPORTS; k++) begin
      if (!busy[k] && !empty[k] &&
          ((head[k].kind == BODY) || (head[k].kind == TAIL))) begin
        pop[k] = 1'b1;
      end
    end
  end

  // Output registers, locks and round-robin pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst == ASSERT) begin
      for (int d = 0; d < NPORTS; d++) begin
        out_q[d]  <= '0;
        locked[d] <= NEGATE;
        owner[d]  <= '0;
        ptr[d]    <= '0;
      end
    end else begin
      for (int d = 0; d < NPORTS; d++) begin
        out_q[d] <= fwd[d];
        if (rel[d]) begin
          locked[d] <= NEGATE;
          ptr[d]    <= owner[d] + PORTW'(1);
        end else if (grant[d]) begin
          locked[d] <= ASSERT;
          owner[d]  <= grant_idx[d];
        end
      end
    end
  end

  assign bus.o0 = out_q[0];
  assign bus.o1 = out_q[1];
  assign bus.o2 = out_q[2];
  assign bus.o3 = out_q[3];

endmodule

// File: tb/tb_pkt_switch4.sv
// Testbench for pkt_switch4: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference model of the switch rules.
module tb_pkt_switch4;
  import sw_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic rst;

  pkt_switch4_if bus ();

  pkt_switch4 #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_bad;
  int          ncyc;

  // Reference model state
  flit_t mq [4][$];
  int    owner [4];
  int    ptr   [4];
  flit_t exp_o [4];
  flit_t drv   [4];

  function automatic flit_t mk(input logic [1:0] kind, input logic [7:0] pl);
    flit_t f;
    f.kind    = kind;
    f.payload = pl;
    return f;
  endfunction

  function automatic flit_t dut_o(input int d);
    case (d)
      0:       return bus.o0;
      1:       return bus.o1;
      2:       return bus.o2;
      default: return bus.o3;
    endcase
  endfunction

  task automatic check(input string tag, input flit_t got, input flit_t want);
    n_vec++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      owner[k] = -1;
      ptr[k]   = 0;
      exp_o[k] = '0;
    end
  endfunction

  // One rising edge of the switch, in terms of packets, queues and owners
  function automatic void model_edge();
    bit    busy [4];
    bit    popped [4];
    flit_t f;
    int    k;
    bit    found;
    for (int i = 0; i < 4; i++) begin
      busy[i]   = 1'b0;
      popped[i] = 1'b0;
    end
    for (int d = 0; d < 4; d++) if (owner[d] >= 0) busy[owner[d]] = 1'b1;

    for (int d = 0; d < 4; d++) begin
      exp_o[d] = '0;
      if (owner[d] >= 0) begin
        k = owner[d];
        if (mq[k].size() > 0) begin
          f         = mq[k].pop_front();
          popped[k] = 1'b1;
          exp_o[d]  = f;
          if (f.kind == TAIL) begin
            owner[d] = -1;
            ptr[d]   = (k + 1) % 4;
          end
        end
      end else begin
        found = 1'b0;
        for (int n = 0; n < 4; n++) begin
          k = (ptr[d] + n) % 4;
          if (!found && !busy[k] && !popped[k] && mq[k].size() > 0 &&
              mq[k][0].kind == HEAD && int'(mq[k][0].payload[1:0]) == d) begin
            found     = 1'b1;
            exp_o[d]  = mq[k].pop_front();
            popped[k] = 1'b1;
            owner[d]  = k;
          end
        end
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (!busy[i] && !popped[i] && mq[i].size() > 0 &&
          (mq[i][0].kind == BODY || mq[i][0].kind == TAIL)) begin
        void'(mq[i].pop_front());
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (drv[i].kind != IDLE && mq[i].size() < DEPTH) mq[i].push_back(drv[i]);
    end
  endfunction

  // Drive one cycle of inputs, advance model, compare all outputs
  task automatic cyc(input flit_t a0, input flit_t a1, input flit_t a2, input flit_t a3);
    drv[0] = a0; drv[1] = a1; drv[2] = a2; drv[3] = a3;
    bus.i0 = a0; bus.i1 = a1; bus.i2 = a2; bus.i3 = a3;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int d = 0; d < 4; d++) check($sformatf("cyc%0d_o%0d", ncyc, d), dut_o(d), exp_o[d]);
    ncyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, '0, '0, '0);
  endtask

  task automatic do_reset();
    bus.i0 = '0; bus.i1 = '0; bus.i2 = '0; bus.i3 = '0;
    rst = ASSERT;
    #1;
    model_reset();
    for (int d = 0; d < 4; d++) check($sformatf("rst_now_o%0d", d), dut_o(d), '0);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) check($sformatf("rst_hold_o%0d", d), dut_o(d), '0);
    rst = NEGATE;
  endtask

  initial begin
    flit_t a [4];
    flit_t got [$];
    flit_t want [$];
    int    first;
    int    rem [4];
    int    r;

    n_vec = 0;
    n_bad = 0;
    ncyc  = 0;
    rst   = NEGATE;
    model_reset();

    // Reset then idle
    do_reset();
    idle(3);

    // Single route on port 0
    cyc(mk(HEAD, 8'h00), '0, '0, '0);
    cyc(mk(BODY, 8'h00), '0, '0, '0);
    check("single_f0", bus.o0, mk(HEAD, 8'h00));
    cyc(mk(BODY, 8'h01), '0, '0, '0);
    check("single_f1", bus.o0, mk(BODY, 8'h00));
    cyc(mk(TAIL, 8'h02), '0, '0, '0);
    check("single_f2", bus.o0, mk(BODY, 8'h01));
    idle(1);
    check("single_f3", bus.o0, mk(TAIL, 8'h02));
    idle(1);
    check("single_done", bus.o0, '0);
    idle(2);

    // 4-way conflict to port 1; port 1 pointer still at 0
    for (int s = 0; s < 4; s++) begin
      want.push_back(mk(HEAD, {4'(s), 4'h1}));
      want.push_back(mk(BODY, {4'(s), 4'h1}));
      want.push_back(mk(BODY, {4'(s), 4'h2}));
      want.push_back(mk(TAIL, {4'(s), 4'hF}));
    end
    for (int c = 0; c < 24; c++) begin
      for (int s = 0; s < 4; s++) begin
        a[s] = '0;
        if (c < 4) a[s] = want[s*4 + c];
      end
      cyc(a[0], a[1], a[2], a[3]);
      got.push_back(bus.o1);
    end
    first = 0;
    for (int i = got.size() - 1; i >= 0; i--) if (got[i] != '0) first = i;
    for (int i = 0; i < 16; i++) begin
      if (first + i < got.size()) check($sformatf("conflict_f%0d", i), got[first + i], want[i]);
      else check($sformatf("conflict_f%0d", i), '0, want[i]);
    end

    // Full route matrix, latency 2
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 4; d++) begin
        for (int i = 0; i < 4; i++) a[i] = '0;
        a[s] = mk(HEAD, {4'(s), 2'b00, 2'(d)});
        cyc(a[0], a[1], a[2], a[3]);
        a[s] = mk(TAIL, {4'(s), 4'hF});
        cyc(a[0], a[1], a[2], a[3]);
        check($sformatf("matrix_s%0d_d%0d_head", s, d), dut_o(d), mk(HEAD, {4'(s), 2'b00, 2'(d)}));
        idle(1);
        check($sformatf("matrix_s%0d_d%0d_tail", s, d), dut_o(d), mk(TAIL, {4'(s), 4'hF}));
        idle(2);
      end
    end

    // Round-robin fairness: 2-flit conflict to each port
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < 4; s++) a[s] = mk(HEAD, {4'(s), 2'b00, 2'(d)});
      cyc(a[0], a[1], a[2], a[3]);
      for (int s = 0; s < 4; s++) a[s] = mk(TAIL, {4'(s), 4'hE});
      cyc(a[0], a[1], a[2], a[3]);
      idle(12);
    end

    // Mid-packet stall on port 3; input 0 must not interleave
    cyc('0, '0, mk(HEAD, 8'h23), '0);
    cyc('0, '0, mk(BODY, 8'h21), '0);
    cyc(mk(HEAD, 8'h03), '0, '0, '0);
    cyc(mk(TAIL, 8'h0F), '0, '0, '0);
    check("stall_gap0", bus.o3, '0);
    cyc('0, '0, mk(BODY, 8'h22), '0);
    check("stall_gap1", bus.o3, '0);
    cyc('0, '0, mk(TAIL, 8'h2F), '0);
    check("stall_resume", bus.o3, mk(BODY, 8'h22));
    idle(1);
    check("stall_tail", bus.o3, mk(TAIL, 8'h2F));
    idle(1);
    check("stall_next", bus.o3, mk(HEAD, 8'h03));
    idle(3);

    // Reset mid-packet, then a fresh packet routes
    cyc('0, mk(HEAD, 8'h12), '0, '0);
    cyc('0, mk(BODY, 8'h11), '0, '0);
    do_reset();
    cyc('0, mk(HEAD, 8'h12), '0, '0);
    cyc('0, mk(TAIL, 8'h1F), '0, '0);
    check("post_rst_head", bus.o2, mk(HEAD, 8'h12));
    idle(3);

    // Random traffic, including strays and FIFO overflow
    for (int i = 0; i < 4; i++) rem[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 750) begin
        do_reset();
        for (int i = 0; i < 4; i++) rem[i] = 0;
      end
      for (int k = 0; k < 4; k++) begin
        r    = int'($urandom_range(0, 99));
        a[k] = '0;
        if (rem[k] == 0) begin
          if (r < 35) begin
            rem[k] = int'($urandom_range(1, 4));
            a[k]   = mk(HEAD, {4'(k), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
          end else if (r < 38) begin
            a[k] = mk((r == 36) ? TAIL : BODY, 8'($urandom));
          end
        end else if (r < 70) begin
          rem[k]--;
          a[k] = mk((rem[k] == 0) ? TAIL : BODY, 8'($urandom));
        end
      end
      cyc(a[0], a[1], a[2], a[3]);
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
